stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Stopwatch core driven by the 10 Hz roll-over tick produced by the clock-divider stage. It counts elapsed time in BCD as MM:SS.t (tenths, seconds, minutes) and is controlled by three push-buttons (start/stop, lap, clear). It has a start/stop/lap state machine and a frozen lap display. Its BCD digit outputs feed the seven-segment decoders of the board top level.

## Interface

Parameters:
- SYNC_STAGES, default 2 — number of synchronizer flops on each button input (≥2).
- WRAP, default 1 — 1: count wraps 59:59.9→00:00.0; 0: count saturates at 59:59.9 and stops.

Ports:
- clk  input  1  — system clock (50 MHz on board); single clock domain.
- reset_n  input  1  — asynchronous, active-low reset.
- tick  input  1  — one-cycle pulse at 10 Hz, synchronous to clk.
- key_start_n  input  1  — raw start/stop button, active-low, asynchronous to clk.
- key_lap_n  input  1  — raw lap button, active-low, asynchronous.
- key_clear_n  input  1  — raw clear button, active-low, asynchronous.
- d_tenth  output  4  — displayed tenths digit, 0–9.
- d_sec_lo  output  4  — displayed seconds ones digit, 0–9.
- d_sec_hi  output  4  — displayed seconds tens digit, 0–5.
- d_min_lo  output  4  — displayed minutes ones digit, 0–9.
- d_min_hi  output  4  — displayed minutes tens digit, 0–5.
- running  output  1  — high in RUN or LAP.
- lap_frozen  output  1  — high in LAP.
- ovf  output  1  — one-cycle pulse on wrap or saturation.

## Operation

- Button path: each key passes through a SYNC_STAGES-deep synchronizer whose flops reset to 1. It then goes through a falling-edge detector that produces a one-cycle event pulse (start_ev, lap_ev, clr_ev). Holding a key produces exactly one event. No debouncing is done here; the upstream design guarantees clean keys.
- Event priority within one cycle: clear > start > lap. Only the highest-priority event is acted on; the others are dropped.
- The FSM has four states (IDLE, RUN, PAUSE, LAP) and resets to IDLE.
  - IDLE: start_ev→RUN. lap_ev and clr_ev are ignored.
  - RUN: start_ev→PAUSE. lap_ev→LAP and copies the live count into the lap register. clr_ev is ignored.
  - LAP: lap_ev→RUN, and the display returns to live. start_ev→PAUSE, and the display returns to live. clr_ev is ignored.
  - PAUSE: start_ev→RUN. clr_ev→IDLE and zeroes the live count in the same edge. lap_ev is ignored.
- Live counter: five BCD digits in a cascade. It increments by one tenth on tick only when the current (pre-transition) state is RUN or LAP.
  - Digit carries: tenth 9→0 carries into sec_lo; sec_lo 9→0 into sec_hi; sec_hi 5→0 into min_lo; min_lo 9→0 into min_hi.
  - The count never holds a non-BCD value, and no digit exceeds its limit.
- Counter at 59:59.9 when tick arrives in RUN or LAP:
  - WRAP=1: the count goes to 00:00.0, ovf pulses, and the state is unchanged.
  - WRAP=0: the count holds at 59:59.9, ovf pulses, and the FSM goes to PAUSE. If the FSM was in LAP, the display returns to live.
- Display: outputs show the lap register in LAP and the live count in every other state. Outputs are a register-only mux; there is no combinational path from any input to any output.

## Timing

- Reset (asynchronous assert, synchronous-safe release):
  - All digits are 0 and the lap register is 0.
  - running=0, lap_frozen=0, ovf=0, state=IDLE.
  - Synchronizer flops are 1, so no spurious event is produced at release.
- Button latency: a key sampled low at rising edge n produces its event pulse in cycle n+SYNC_STAGES. The state and count update at edge n+SYNC_STAGES+1, which is 3 edges for the default.
- Tick latency: the count updates at the edge that samples tick high.
- Tick and event in the same cycle:
  - Tick with start_ev in IDLE or PAUSE: no increment.
  - Tick with start_ev in RUN: increments.
  - Tick with lap_ev in RUN: the lap register captures the pre-increment value, and the live count increments.
- ovf is high for exactly the cycle after the wrapping or saturating tick edge.
- Reset asserted mid-count clears everything immediately, regardless of clk.

## Test plan

- Reset, start, tick: reset, press start, apply 10 ticks → display 00:01.0 and running=1. Press start again → PAUSE; 5 more ticks leave the display at 00:01.0.
- Carry chain: in RUN, apply 599 ticks → 00:59.9. One more tick → 01:00.0. Preload to 59:59.9 with WRAP=1, then one tick → 00:00.0 with a one-cycle ovf and running=1.
- Saturation: with WRAP=0, from 59:59.9 apply one tick → display holds 59:59.9, ovf pulses, FSM in PAUSE, running=0.
- Lap: in RUN at 00:02.3, press lap → display frozen at 00:02.3 and lap_frozen=1. After 7 ticks the display is still 00:02.3. Press lap → display 00:03.0.
- Priority and clear: press start and clear in the same cycle while in PAUSE → IDLE with the count 00:00.0. Press clear in RUN → ignored. Press clear in PAUSE → 00:00.0 after exactly SYNC_STAGES+1 edges.
- Async reset mid-run: assert reset_n=0 between clk edges during RUN at 12:34.5 → all outputs 0 and state IDLE without waiting for a clk edge. Holding a key low through reset release produces no event.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// Stopwatch core that counts elapsed time as BCD MM:SS.t from a 10 Hz tick.
// Three raw push-buttons (start/stop, lap, clear) are synchronized and
// edge-detected. A four-state FSM (IDLE/RUN/PAUSE/LAP) controls counting and
// a frozen lap display.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per button (>= 2)
//   WRAP         1: 59:59.9 wraps to 00:00.0; 0: saturates and pauses
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   tick         one-cycle 10 Hz count enable
//   key_start_n  raw start/stop button, active-low, asynchronous
//   key_lap_n    raw lap button, active-low, asynchronous
//   key_clear_n  raw clear button, active-low, asynchronous
//   d_tenth      displayed tenths digit
//   d_sec_lo     displayed seconds ones digit
//   d_sec_hi     displayed seconds tens digit
//   d_min_lo     displayed minutes ones digit
//   d_min_hi     displayed minutes tens digit
//   running      high in RUN or LAP
//   lap_frozen   high in LAP
//   ovf          one-cycle pulse on wrap or saturation
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
    parameter int SYNC_STAGES = 2,
    parameter int WRAP        = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       key_clear_n,
    output logic [3:0] d_tenth,
    output logic [3:0] d_sec_lo,
    output logic [3:0] d_sec_hi,
    output logic [3:0] d_min_lo,
    output logic [3:0] d_min_hi,
    output logic       running,
    output logic       lap_frozen,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // Packed count layout, one nibble per digit:
    // [3:0] tenth, [7:4] sec_lo, [11:8] sec_hi, [15:12] min_lo, [19:16] min_hi
    localparam logic [19:0] MAX_COUNT = 20'h59599;

    // ------------------------------------------------------------------
    // Button path: synchronizer -> falling-edge detector -> event pulse
    // ------------------------------------------------------------------
    logic [2:0] key_raw;   // bit 0 start, bit 1 lap, bit 2 clear
    logic [2:0] key_ev;

    assign key_raw = {key_clear_n, key_lap_n, key_start_n};

    // Marks when the last synchronizer stage holds a genuinely sampled value
    // rather than its reset preset. Until then, the edge detector treats the
    // key as pressed, so a key held down through reset release only arms on
    // its first release and never yields an event.
    logic [SYNC_STAGES-1:0] vld_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   ev_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '1;
                    prev_reg <= 1'b0;
                    ev_reg   <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_raw[gi]};
                    prev_reg <= vld_reg[SYNC_STAGES-1] & sync_reg[SYNC_STAGES-1];
                    // Registered pulse: event is visible one cycle after the
                    // synchronized level falls.
                    ev_reg   <= vld_reg[SYNC_STAGES-1] & prev_reg
                                & ~sync_reg[SYNC_STAGES-1];
                end
            end

            assign key_ev[gi] = ev_reg;
        end
    endgenerate

    // Priority resolution: clear > start > lap; lower events are dropped.
    logic clr_ev;
    logic start_ev;
    logic lap_ev;

    assign clr_ev   = key_ev[2];
    assign start_ev = key_ev[0] & ~key_ev[2];
    assign lap_ev   = key_ev[1] & ~key_ev[0] & ~key_ev[2];

    // ------------------------------------------------------------------
    // Live counter increment cascade
    // ------------------------------------------------------------------
    logic [19:0] live_reg;
    logic [19:0] live_inc;
    logic [4:0]  carry;

    assign carry[0] = 1'b1;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_digit
            // Tens digits of seconds and minutes roll at 5, the rest at 9.
            localparam logic [3:0] LIM = (gi == 2 || gi == 4) ? 4'd5 : 4'd9;
            logic at_lim;

            assign at_lim = (live_reg[4*gi +: 4] == LIM);

            if (gi < 4) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_lim;
            end

            assign live_inc[4*gi +: 4] = !carry[gi] ? live_reg[4*gi +: 4] :
                                         at_lim     ? 4'd0 :
                                                      live_reg[4*gi +: 4] + 4'd1;
        end
    endgenerate

    logic at_max;
    assign at_max = (live_reg == MAX_COUNT);

    // ------------------------------------------------------------------
    // FSM and datapath next-state
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [19:0] live_next;
    logic [19:0] lap_reg;
    logic [19:0] lap_next;
    logic [19:0] disp_reg;
    logic [19:0] disp_next;
    logic        ovf_next;
    logic        running_reg;
    logic        lap_frozen_reg;
    logic        ovf_reg;

    always_comb begin
        state_next = state_reg;
        live_next  = live_reg;
        lap_next   = lap_reg;
        ovf_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_ev) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start_ev) begin
                    state_next = PAUSE;
                end else if (lap_ev) begin
                    state_next = LAP;
                    lap_next   = live_reg;  // pre-increment snapshot
                end
            end
            LAP: begin
                if (start_ev) begin
                    state_next = PAUSE;
                end else if (lap_ev) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (start_ev) begin
                    state_next = RUN;
                end else if (clr_ev) begin
                    state_next = IDLE;
                    live_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Counting depends on the state before any transition this cycle.
        if (tick && (state_reg == RUN || state_reg == LAP)) begin
            ovf_next = at_max;
            if (at_max && (WRAP == 0)) begin
                // Saturate: hold the count and force a pause, which also
                // drops any lap freeze.
                state_next = PAUSE;
            end else begin
                live_next = live_inc;
            end
        end

        disp_next = (state_next == LAP) ? lap_next : live_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            live_reg       <= '0;
            lap_reg        <= '0;
            disp_reg       <= '0;
            running_reg    <= 1'b0;
            lap_frozen_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            live_reg       <= live_next;
            lap_reg        <= lap_next;
            disp_reg       <= disp_next;
            running_reg    <= (state_next == RUN) || (state_next == LAP);
            lap_frozen_reg <= (state_next == LAP);
            ovf_reg        <= ovf_next;
        end
    end

    // All outputs come straight from registers.
    assign d_tenth    = disp_reg[3:0];
    assign d_sec_lo   = disp_reg[7:4];
    assign d_sec_hi   = disp_reg[11:8];
    assign d_min_lo   = disp_reg[15:12];
    assign d_min_hi   = disp_reg[19:16];
    assign running    = running_reg;
    assign lap_frozen = lap_frozen_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd
//
// Directed bench for stopwatch_bcd. Two instances share every input: one with
// WRAP=1 (main checks) and one with WRAP=0 (saturation checks). Inputs change
// on the falling edge and outputs are sampled on the falling edge.
// Displays are compared as packed hex {min_hi,min_lo,sec_hi,sec_lo,tenth},
// so 12:34.5 reads 20'h12345.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic tick;
    logic key_start_n;
    logic key_lap_n;
    logic key_clear_n;

    logic [3:0] w_tenth, w_sec_lo, w_sec_hi, w_min_lo, w_min_hi;
    logic       w_running, w_lap_frozen, w_ovf;
    logic [3:0] s_tenth, s_sec_lo, s_sec_hi, s_min_lo, s_min_hi;
    logic       s_running, s_lap_frozen, s_ovf;

    logic [19:0] w_disp;
    logic [19:0] s_disp;

    assign w_disp = {w_min_hi, w_min_lo, w_sec_hi, w_sec_lo, w_tenth};
    assign s_disp = {s_min_hi, s_min_lo, s_sec_hi, s_sec_lo, s_tenth};

    stopwatch_bcd #(.SYNC_STAGES(2), .WRAP(1)) dut_w (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clear_n (key_clear_n),
        .d_tenth     (w_tenth),
        .d_sec_lo    (w_sec_lo),
        .d_sec_hi    (w_sec_hi),
        .d_min_lo    (w_min_lo),
        .d_min_hi    (w_min_hi),
        .running     (w_running),
        .lap_frozen  (w_lap_frozen),
        .ovf         (w_ovf)
    );

    stopwatch_bcd #(.SYNC_STAGES(2), .WRAP(0)) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clear_n (key_clear_n),
        .d_tenth     (s_tenth),
        .d_sec_lo    (s_sec_lo),
        .d_sec_hi    (s_sec_hi),
        .d_min_lo    (s_min_lo),
        .d_min_hi    (s_min_hi),
        .running     (s_running),
        .lap_frozen  (s_lap_frozen),
        .ovf         (s_ovf)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Hold tick high for n rising edges, ending on a falling edge.
    task automatic tick_n(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    // One-cycle press of the selected keys {clear, lap, start}; returns after
    // the edge where state and count have updated (3 edges after sampling).
    task automatic press(input logic [2:0] k);
        key_start_n = ~k[0];
        key_lap_n   = ~k[1];
        key_clear_n = ~k[2];
        @(negedge clk);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_clear_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        tick        = 1'b0;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_clear_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_disp",       32'(w_disp),       32'h0);
        chk("rst_running",    32'(w_running),    32'h0);
        chk("rst_lap_frozen", 32'(w_lap_frozen), 32'h0);
        chk("rst_ovf",        32'(w_ovf),        32'h0);

        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_running", 32'(w_running), 32'h0);

        // Start, 10 ticks, pause, ticks ignored
        press(3'b001);
        chk("start_running", 32'(w_running), 32'h1);
        tick_n(10);
        chk("ten_ticks_disp", 32'(w_disp), 32'h00010);
        press(3'b001);
        chk("pause_running", 32'(w_running), 32'h0);
        tick_n(5);
        chk("pause_hold_disp", 32'(w_disp), 32'h00010);

        // Start + clear together in PAUSE: clear wins
        press(3'b101);
        chk("prio_clear_disp",    32'(w_disp),    32'h0);
        chk("prio_clear_running", 32'(w_running), 32'h0);

        // Lap freeze
        press(3'b001);
        chk("restart_running", 32'(w_running), 32'h1);
        tick_n(23);
        chk("pre_lap_disp", 32'(w_disp), 32'h00023);
        press(3'b010);
        chk("lap_frozen_set", 32'(w_lap_frozen), 32'h1);
        chk("lap_disp",       32'(w_disp),       32'h00023);
        tick_n(7);
        chk("lap_frozen_disp", 32'(w_disp),    32'h00023);
        chk("lap_running",     32'(w_running), 32'h1);
        press(3'b010);
        chk("unlap_disp",       32'(w_disp),       32'h00030);
        chk("unlap_lap_frozen", 32'(w_lap_frozen), 32'h0);

        // Clear in RUN is ignored
        press(3'b100);
        chk("clr_in_run_disp",    32'(w_disp),    32'h00030);
        chk("clr_in_run_running", 32'(w_running), 32'h1);

        // Carry chain
        tick_n(569);
        chk("carry_0599", 32'(w_disp), 32'h00599);
        tick_n(1);
        chk("carry_1000", 32'(w_disp), 32'h01000);

        // Clear in PAUSE lands exactly 3 edges after sampling
        press(3'b001);
        chk("pause2_running", 32'(w_running), 32'h0);
        key_clear_n = 1'b0;          // sampled at edge n
        @(negedge clk);
        key_clear_n = 1'b1;
        @(negedge clk);              // after edge n+1
        @(negedge clk);              // after edge n+2
        chk("clr_not_early", 32'(w_disp), 32'h01000);
        @(negedge clk);              // after edge n+3
        chk("clr_on_time",   32'(w_disp),    32'h0);
        chk("clr_idle",      32'(w_running), 32'h0);

        // Run to 12:34.5, then async reset between edges
        press(3'b001);
        tick_n(7545);
        chk("disp_12345", 32'(w_disp), 32'h12345);
        #2;
        reset_n     = 1'b0;
        key_start_n = 1'b0;
        #1;
        chk("async_rst_disp",    32'(w_disp),    32'h0);
        chk("async_rst_running", 32'(w_running), 32'h0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_key_no_event", 32'(w_running), 32'h0);
        key_start_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_key_release_no_event", 32'(w_running), 32'h0);
        press(3'b001);
        chk("post_async_start", 32'(w_running), 32'h1);

        // Run both instances up to 59:59.9
        tick_n(35999);
        chk("w_max_disp", 32'(w_disp), 32'h59599);
        chk("s_max_disp", 32'(s_disp), 32'h59599);
        chk("w_max_ovf",  32'(w_ovf),  32'h0);

        tick_n(1);
        chk("wrap_disp",    32'(w_disp),    32'h0);
        chk("wrap_ovf",     32'(w_ovf),     32'h1);
        chk("wrap_running", 32'(w_running), 32'h1);
        chk("sat_disp",     32'(s_disp),    32'h59599);
        chk("sat_ovf",      32'(s_ovf),     32'h1);
        chk("sat_running",  32'(s_running), 32'h0);
        @(negedge clk);
        chk("wrap_ovf_one_cycle", 32'(w_ovf), 32'h0);
        chk("sat_ovf_one_cycle",  32'(s_ovf), 32'h0);
        tick_n(1);
        chk("wrap_continues", 32'(w_disp), 32'h00001);
        chk("sat_holds",      32'(s_disp), 32'h59599);
        chk("sat_no_ovf",     32'(s_ovf),  32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
